// File: rtl/reg_file_pkg.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_pkg
// Description : Shared widths, grant encoding and write-buffer entry type for
//               the register-file arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package reg_file_pkg;

    localparam int ADDR_W     = 4;
    localparam int DATA_W     = 32;
    localparam int STARVE_MAX = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        READ  = 2'd1,
        WRITE = 2'd2
    } grant_e;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } wbufEntry_t;

endpackage : reg_file_pkg
`default_nettype wire

// File: rtl/wr_buffer.sv
`default_nettype none
// ============================================================================
// Module      : wr_buffer
// Description : Two-entry {addr,data} FIFO with two newest-match lookup ports.
// Revision    : 1.0 - initial release
// ============================================================================
module wr_buffer
    import reg_file_pkg::*;
#(
    parameter int ADDR_W = reg_file_pkg::ADDR_W,
    parameter int DATA_W = reg_file_pkg::DATA_W
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              push,
    input  logic [ADDR_W-1:0] pushAddr,
    input  logic [DATA_W-1:0] pushData,
    input  logic              pop,
    output logic [ADDR_W-1:0] headAddr,
    output logic [DATA_W-1:0] headData,
    output logic [1:0]        count,
    input  logic [ADDR_W-1:0] lkAddrA,
    output logic              lkHitA,
    output logic [DATA_W-1:0] lkDataA,
    input  logic [ADDR_W-1:0] lkAddrB,
    output logic              lkHitB,
    output logic [DATA_W-1:0] lkDataB
);

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] data;
    } entry_t;

    entry_t     r_slot0;   // oldest entry (head)
    entry_t     r_slot1;
    logic [1:0] r_count;
    entry_t     w_new;
    logic       w_push;
    logic       w_pop;

    assign w_new    = '{addr: pushAddr, data: pushData};
    assign w_pop    = pop && (r_count != 2'd0);
    assign w_push   = push && ((r_count != 2'd2) || w_pop);
    assign headAddr = r_slot0.addr;
    assign headData = r_slot0.data;
    assign count    = r_count;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_slot0 <= '0;
            r_slot1 <= '0;
            r_count <= 2'd0;
        end else begin
            case ({w_push, w_pop})
                2'b10: begin
                    if (r_count == 2'd0) r_slot0 <= w_new;
                    else                 r_slot1 <= w_new;
                    r_count <= r_count + 2'd1;
                end
                2'b01: begin
                    r_slot0 <= r_slot1;
                    r_count <= r_count - 2'd1;
                end
                2'b11: begin
                    if (r_count == 2'd2) begin
                        r_slot0 <= r_slot1;
                        r_slot1 <= w_new;
                    end else begin
                        r_slot0 <= w_new;
                    end
                end
                default: ;
            endcase
        end
    end

    // Younger slot checked first so the newest write to an address wins.
    function automatic logic [DATA_W:0] lookup(input logic [ADDR_W-1:0] a,
                                               input entry_t s0, input entry_t s1,
                                               input logic [1:0] cnt);
        logic [DATA_W:0] res;
        res = '0;
        if ((cnt == 2'd2) && (s1.addr == a))      res = {1'b1, s1.data};
        else if ((cnt != 2'd0) && (s0.addr == a)) res = {1'b1, s0.data};
        return res;
    endfunction

    always_comb begin
        {lkHitA, lkDataA} = lookup(lkAddrA, r_slot0, r_slot1, r_count);
        {lkHitB, lkDataB} = lookup(lkAddrB, r_slot0, r_slot1, r_count);
    end

endmodule : wr_buffer
`default_nettype wire

// File: rtl/reg_file_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : reg_file_arbiter
// Description : Single-port register-file arbiter between decode reads and
//               buffered writeback writes, with bypass and starvation limit.
// Revision    : 1.0 - initial release
// ============================================================================
module reg_file_arbiter
    import reg_file_pkg::*;
#(
    parameter int ADDR_W     = reg_file_pkg::ADDR_W,
    parameter int DATA_W     = reg_file_pkg::DATA_W,
    parameter int STARVE_MAX = reg_file_pkg::STARVE_MAX
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic              rd_req,
    input  logic [ADDR_W-1:0] rd_rs,
    input  logic [ADDR_W-1:0] rd_rt,
    output logic              rd_ack,
    output logic [DATA_W-1:0] rd_rs_data,
    output logic [DATA_W-1:0] rd_rt_data,
    input  logic              wr_req,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    output logic              wr_ack,
    output logic              rf_wr,
    output logic [ADDR_W-1:0] rf_rs_addr,
    output logic [ADDR_W-1:0] rf_rt_addr,
    output logic [ADDR_W-1:0] rf_rd_addr,
    output logic [DATA_W-1:0] rf_wdata,
    input  logic [DATA_W-1:0] rf_rs_data,
    input  logic [DATA_W-1:0] rf_rt_data,
    output logic [1:0]        wbuf_count
);

    localparam int                    c_STARVE_W   = $clog2(STARVE_MAX + 1);
    localparam logic [c_STARVE_W-1:0] c_STARVE_MAX = c_STARVE_W'(STARVE_MAX);

    grant_e                  w_grant;
    logic [1:0]              w_count;
    logic [ADDR_W-1:0]       w_headAddr;
    logic [DATA_W-1:0]       w_headData;
    logic                    w_hitRs;
    logic                    w_hitRt;
    logic [DATA_W-1:0]       w_bufRs;
    logic [DATA_W-1:0]       w_bufRt;
    logic                    w_wrAck;

    logic [c_STARVE_W-1:0]   r_starve;
    logic                    r_rdAck;
    logic [DATA_W-1:0]       r_rsData;
    logic [DATA_W-1:0]       r_rtData;
    logic [ADDR_W-1:0]       r_rsAddr;
    logic [ADDR_W-1:0]       r_rtAddr;
    logic [ADDR_W-1:0]       r_rdAddr;
    logic [DATA_W-1:0]       r_wdata;

    wr_buffer #(
        .ADDR_W (ADDR_W),
        .DATA_W (DATA_W)
    ) u_wrBuffer (
        .clk      (clk),
        .reset_n  (reset_n),
        .push     (w_wrAck),
        .pushAddr (wr_addr),
        .pushData (wr_data),
        .pop      (w_grant == WRITE),
        .headAddr (w_headAddr),
        .headData (w_headData),
        .count    (w_count),
        .lkAddrA  (rd_rs),
        .lkHitA   (w_hitRs),
        .lkDataA  (w_bufRs),
        .lkAddrB  (rd_rt),
        .lkHitB   (w_hitRt),
        .lkDataB  (w_bufRt)
    );

    // A full buffer always drains; otherwise reads win until the starve limit.
    always_comb begin
        w_grant = IDLE;
        if (!reset_n)                                 w_grant = IDLE;
        else if (w_count == 2'd2)                     w_grant = WRITE;
        else if (rd_req && (r_starve < c_STARVE_MAX)) w_grant = READ;
        else if (w_count != 2'd0)                     w_grant = WRITE;
        else if (rd_req)                              w_grant = READ;
    end

    assign w_wrAck    = reset_n && wr_req && ((w_count != 2'd2) || (w_grant == WRITE));
    assign wr_ack     = w_wrAck;
    assign wbuf_count = w_count;
    assign rf_wr      = (w_grant == WRITE);
    assign rf_rs_addr = (w_grant == READ)  ? rd_rs      : r_rsAddr;
    assign rf_rt_addr = (w_grant == READ)  ? rd_rt      : r_rtAddr;
    assign rf_rd_addr = (w_grant == WRITE) ? w_headAddr : r_rdAddr;
    assign rf_wdata   = (w_grant == WRITE) ? w_headData : r_wdata;
    assign rd_ack     = r_rdAck;
    assign rd_rs_data = r_rsData;
    assign rd_rt_data = r_rtData;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            r_starve <= '0;
            r_rdAck  <= 1'b0;
            r_rsData <= '0;
            r_rtData <= '0;
            r_rsAddr <= '0;
            r_rtAddr <= '0;
            r_rdAddr <= '0;
            r_wdata  <= '0;
        end else begin
            r_rdAck <= (w_grant == READ);
            if (w_grant == READ) begin
                r_rsAddr <= rd_rs;
                r_rtAddr <= rd_rt;
                r_rsData <= w_hitRs ? w_bufRs : rf_rs_data;
                r_rtData <= w_hitRt ? w_bufRt : rf_rt_data;
            end
            if (w_grant == WRITE) begin
                r_rdAddr <= w_headAddr;
                r_wdata  <= w_headData;
            end
            if ((w_grant == WRITE) || (w_count == 2'd0)) begin
                r_starve <= '0;
            end else if ((w_grant == READ) && (r_starve != c_STARVE_MAX)) begin
                r_starve <= r_starve + 1'b1;
            end
        end
    end

endmodule : reg_file_arbiter
`default_nettype wire

// File: tb/tb_reg_file_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_reg_file_arbiter
// Description : Scoreboard bench for reg_file_arbiter with a queue-based model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_reg_file_arbiter;

    localparam int AW   = 4;
    localparam int DW   = 32;
    localparam int SMAX = 4;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          rd_req = 1'b0;
    logic [AW-1:0] rd_rs = '0;
    logic [AW-1:0] rd_rt = '0;
    logic          rd_ack;
    logic [DW-1:0] rd_rs_data;
    logic [DW-1:0] rd_rt_data;
    logic          wr_req = 1'b0;
    logic [AW-1:0] wr_addr = '0;
    logic [DW-1:0] wr_data = '0;
    logic          wr_ack;
    logic          rf_wr;
    logic [AW-1:0] rf_rs_addr;
    logic [AW-1:0] rf_rt_addr;
    logic [AW-1:0] rf_rd_addr;
    logic [DW-1:0] rf_wdata;
    logic [DW-1:0] rf_rs_data;
    logic [DW-1:0] rf_rt_data;
    logic [1:0]    wbuf_count;

    always #5 clk = ~clk;

    reg_file_arbiter #(.ADDR_W(AW), .DATA_W(DW), .STARVE_MAX(SMAX)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .rd_req     (rd_req),
        .rd_rs      (rd_rs),
        .rd_rt      (rd_rt),
        .rd_ack     (rd_ack),
        .rd_rs_data (rd_rs_data),
        .rd_rt_data (rd_rt_data),
        .wr_req     (wr_req),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .wr_ack     (wr_ack),
        .rf_wr      (rf_wr),
        .rf_rs_addr (rf_rs_addr),
        .rf_rt_addr (rf_rt_addr),
        .rf_rd_addr (rf_rd_addr),
        .rf_wdata   (rf_wdata),
        .rf_rs_data (rf_rs_data),
        .rf_rt_data (rf_rt_data),
        .wbuf_count (wbuf_count)
    );

    function automatic logic [DW-1:0] initVal(input int i);
        return 32'hA5A5_0000 + DW'(i * 32'h0000_0111);
    endfunction

    // Physical register file attached to the arbiter.
    logic [DW-1:0] tbRf [16];
    logic          tbInitDone = 1'b0;
    always @(posedge clk) begin
        if (!tbInitDone) begin
            for (int i = 0; i < 16; i++) tbRf[i] <= initVal(i);
        end else if (rf_wr) begin
            tbRf[rf_rd_addr] <= rf_wdata;
        end
    end
    assign rf_rs_data = tbRf[rf_rs_addr];
    assign rf_rt_data = tbRf[rf_rt_addr];

    typedef struct packed { logic [AW-1:0] a; logic [DW-1:0] d; } wr_t;
    typedef struct packed { logic [DW-1:0] rs; logic [DW-1:0] rt; } rd_t;

    wr_t           mq[$];
    rd_t           expQ[$];
    logic [DW-1:0] mRf [16];
    int            mStarve = 0;
    logic [AW-1:0] mRs = '0, mRt = '0, mRd = '0;
    logic [DW-1:0] mWd = '0;
    int            errCnt = 0;
    int            chkCnt = 0;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        chkCnt++;
        if (act !== exp) begin
            errCnt++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
        end
    endtask

    // Newest value of a register as seen by a reader: later buffered writes override.
    function automatic logic [DW-1:0] mRead(input logic [AW-1:0] a);
        logic [DW-1:0] v;
        v = mRf[a];
        foreach (mq[i]) if (mq[i].a == a) v = mq[i].d;
        return v;
    endfunction

    // One clock of stimulus plus reference-model evaluation.
    task automatic step(input bit keep, input logic rq, input logic [AW-1:0] rs,
                        input logic [AW-1:0] rt, input logic wq,
                        input logic [AW-1:0] wa, input logic [DW-1:0] wd);
        int g;
        int cnt;
        bit ackExp;
        @(negedge clk); #1;
        if (!(keep && rd_req && !rd_ack)) begin
            rd_req = rq; rd_rs = rs; rd_rt = rt;
        end
        wr_req = wq; wr_addr = wa; wr_data = wd;
        #1;
        cnt = mq.size();
        if (cnt == 2)                      g = 2;
        else if (rd_req && mStarve < SMAX) g = 1;
        else if (cnt > 0)                  g = 2;
        else if (rd_req)                   g = 1;
        else                               g = 0;
        ackExp = wr_req && (cnt < 2 || g == 2);
        chk("wbuf_count", 64'(wbuf_count), 64'(cnt));
        chk("wr_ack", 64'(wr_ack), 64'(ackExp));
        chk("rf_wr", 64'(rf_wr), 64'(g == 2));
        if (g == 1) begin
            mRs = rd_rs; mRt = rd_rt;
            expQ.push_back('{rs: mRead(rd_rs), rt: mRead(rd_rt)});
        end
        if (g == 2) begin
            mRd = mq[0].a; mWd = mq[0].d;
        end
        chk("rf_rs_addr", 64'(rf_rs_addr), 64'(mRs));
        chk("rf_rt_addr", 64'(rf_rt_addr), 64'(mRt));
        chk("rf_rd_addr", 64'(rf_rd_addr), 64'(mRd));
        chk("rf_wdata", 64'(rf_wdata), 64'(mWd));
        if (g == 2 || cnt == 0) mStarve = 0;
        else if (g == 1)        mStarve = (mStarve + 1 > SMAX) ? SMAX : mStarve + 1;
        if (g == 2) begin
            mRf[mq[0].a] = mq[0].d;
            void'(mq.pop_front());
        end
        if (ackExp) mq.push_back('{a: wr_addr, d: wr_data});
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
    endtask

    task automatic doReset(input int n);
        @(negedge clk); #1;
        reset_n = 1'b0; rd_req = 1'b0; wr_req = 1'b0;
        #1;
        chk("rst_rd_ack", 64'(rd_ack), 64'(0));
        chk("rst_count", 64'(wbuf_count), 64'(0));
        chk("rst_rf_wr", 64'(rf_wr), 64'(0));
        chk("rst_rs_data", 64'(rd_rs_data), 64'(0));
        chk("rst_rt_data", 64'(rd_rt_data), 64'(0));
        chk("rst_rf_addrs", 64'({rf_rs_addr, rf_rt_addr, rf_rd_addr}), 64'(0));
        chk("rst_rf_wdata", 64'(rf_wdata), 64'(0));
        mq.delete(); expQ.delete();
        mStarve = 0; mRs = '0; mRt = '0; mRd = '0; mWd = '0;
        repeat (n) @(negedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    // Monitor: every rd_ack must match the oldest predicted read.
    always @(negedge clk) begin
        if (rd_ack) begin
            if (expQ.size() == 0) begin
                chk("rd_ack_unexpected", 64'(1), 64'(0));
            end else begin
                rd_t e;
                e = expQ.pop_front();
                chk("rd_rs_data", 64'(rd_rs_data), 64'(e.rs));
                chk("rd_rt_data", 64'(rd_rt_data), 64'(e.rt));
            end
        end
    end

    initial begin
        repeat (2) @(negedge clk);
        tbInitDone = 1'b1;
        for (int i = 0; i < 16; i++) mRf[i] = initVal(i);
        doReset(1);

        // Plain read from an empty buffer.
        step(1'b0, 1'b1, 4'd3, 4'd7, 1'b0, '0, '0);
        chk("read_rf_wr", 64'(rf_wr), 64'(0));

        // Bypass of a buffered write.
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd5, 32'hDEAD);
        step(1'b0, 1'b1, 4'd5, 4'd5, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        chk("bypass_dead", 64'(rd_rs_data), 64'(32'hDEAD));

        // Same-address ordering and bypass before drain.
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd2, 32'd1);
        step(1'b0, 1'b1, 4'd2, 4'd2, 1'b1, 4'd2, 32'd2);
        step(1'b0, 1'b1, 4'd2, 4'd2, 1'b0, '0, '0);
        step(1'b0, 1'b1, 4'd2, 4'd2, 1'b0, '0, '0);
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        chk("bypass_r2", 64'(rd_rs_data), 64'(2));
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        chk("rf_r2_final", 64'(tbRf[2]), 64'(2));

        // Full buffer: third write accepted alongside the forced WRITE.
        step(1'b0, 1'b1, 4'd0, 4'd1, 1'b1, 4'd1, 32'd11);
        step(1'b0, 1'b1, 4'd0, 4'd1, 1'b1, 4'd1, 32'd12);
        step(1'b0, 1'b1, 4'd0, 4'd1, 1'b1, 4'd4, 32'd44);
        chk("full_wr_ack", 64'(wr_ack), 64'(1));
        chk("full_grant_write", 64'(rf_wr), 64'(1));
        step(1'b0, 1'b0, '0, '0, 1'b0, '0, '0);
        chk("full_count_kept", 64'(wbuf_count), 64'(2));
        idle(2);

        // Starvation limit: four reads, then a forced write.
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd6, 32'h66);
        for (int i = 0; i < 5; i++) begin
            step(1'b0, 1'b1, AW'(i), AW'(i + 8), 1'b0, '0, '0);
            chk("starve_seq", 64'(rf_wr), 64'(i == 4));
        end
        step(1'b0, 1'b1, 4'd6, 4'd6, 1'b0, '0, '0);
        chk("starve_cleared_read", 64'(rf_wr), 64'(0));

        // Reset while two writes are buffered.
        idle(2);
        step(1'b0, 1'b0, '0, '0, 1'b1, 4'd7, 32'h77);
        step(1'b0, 1'b1, 4'd1, 4'd1, 1'b1, 4'd8, 32'h88);
        doReset(1);
        idle(3);
        chk("reset_r7_kept", 64'(tbRf[7]), 64'(initVal(7)));
        chk("reset_r8_kept", 64'(tbRf[8]), 64'(initVal(8)));

        // Randomized traffic with a reset in the middle.
        for (int n = 0; n < 600; n++) begin
            if (n == 300) doReset(2);
            step(1'b1, 1'($urandom_range(0, 1)), AW'($urandom_range(0, 15)),
                 AW'($urandom_range(0, 15)), 1'($urandom_range(0, 9) < 4),
                 AW'($urandom_range(0, 5)), DW'($urandom));
        end
        idle(8);
        chk("exp_queue_drained", 64'(expQ.size()), 64'(0));
        chk("model_buffer_drained", 64'(wbuf_count), 64'(0));

        $display("Result: errors=%0d of %0d checks", errCnt, chkCnt);
        $finish;
    end

endmodule : tb_reg_file_arbiter
`default_nettype wire
